// File: rtl/bit_collector.sv
// bit_collector: assembles ASCII '0'/'1' keystrokes into a WIDTH-bit word with write strobes for a bit-reversal RAM
module bit_collector #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_bit,
    output logic [ADDR_W-1:0] addr,
    output logic              err,
    output logic [WIDTH-1:0]  word_out,
    output logic [WIDTH-1:0]  word_rev,
    output logic              word_valid,
    input  logic              word_ready
);
    typedef enum logic {COLLECT, FULL} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d, wr_bit_q, wr_bit_d, err_q, err_d;
    logic [WIDTH-1:0]  word_q, word_d, cur_mask, prev_mask;
    logic              accept, is_digit, is_bs, last;
    assign char_ready = state_q == COLLECT;
    assign accept     = char_valid & char_ready & ~clear;
    assign is_digit   = char_data == 8'h30 || char_data == 8'h31;
    assign is_bs      = char_data == 8'h08;
    assign last       = addr_q == ADDR_W'(WIDTH - 1);
    assign cur_mask   = WIDTH'(1) << addr_q;
    assign prev_mask  = WIDTH'(1) << (addr_q - 1'b1);
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        word_d    = word_q;
        wr_addr_d = wr_addr_q;
        wr_bit_d  = wr_bit_q;
        wr_en_d   = 1'b0;
        err_d     = 1'b0;
        if (state_q == FULL) begin
            state_d = word_ready ? COLLECT : FULL;
            word_d  = word_ready ? '0 : word_q;
        end else if (clear) begin
            addr_d = '0;
            word_d = '0;
        end else if (accept && is_digit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_bit_d  = char_data[0];
            word_d    = char_data[0] ? (word_q | cur_mask) : (word_q & ~cur_mask);
            addr_d    = last ? '0 : addr_q + 1'b1;
            state_d   = last ? FULL : COLLECT;
        end else if (accept && is_bs) begin
            addr_d = (addr_q != '0) ? addr_q - 1'b1 : addr_q;
            word_d = (addr_q != '0) ? (word_q & ~prev_mask) : word_q;
        end else if (accept) begin
            err_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= COLLECT;
            addr_q    <= '0;
            word_q    <= '0;
            wr_addr_q <= '0;
            wr_bit_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            word_q    <= word_d;
            wr_addr_q <= wr_addr_d;
            wr_bit_q  <= wr_bit_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
        end
    end
    always_comb begin
        for (int i = 0; i < WIDTH; i++) word_rev[i] = word_q[WIDTH-1-i];
    end
    assign addr       = addr_q;
    assign wr_addr    = wr_addr_q;
    assign wr_bit     = wr_bit_q;
    assign wr_en      = wr_en_q;
    assign err        = err_q;
    assign word_out   = word_q;
    assign word_valid = state_q == FULL;
endmodule

// File: tb/tb_bit_collector.sv
// tb_bit_collector: directed scenarios plus randomized traffic against a queue-based reference model
module tb_bit_collector;
    localparam int W  = 8;
    localparam int AW = 4;
    logic          clk = 1'b0;
    logic          reset = 1'b1, clear = 1'b0, char_valid = 1'b0, word_ready = 1'b0;
    logic [7:0]    char_data = 8'h00;
    logic          char_ready, wr_en, wr_bit, err, word_valid;
    logic [AW-1:0] wr_addr, addr;
    logic [W-1:0]  word_out, word_rev;
    int            tests = 0, fails = 0;
    bit            mq[$];
    bit            m_full, m_wr_en, m_err, m_wr_bit;
    logic [AW-1:0] m_wr_addr;

    bit_collector #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_bit(wr_bit), .addr(addr),
        .err(err), .word_out(word_out), .word_rev(word_rev), .word_valid(word_valid),
        .word_ready(word_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_word();
        logic [W-1:0] w = '0;
        foreach (mq[i]) w[i] = mq[i];
        return w;
    endfunction

    function automatic logic [W-1:0] reverse(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[W-1-i] = x[i];
        return r;
    endfunction

    function automatic logic [AW-1:0] m_addr();
        return m_full ? '0 : AW'(mq.size());
    endfunction

    // Applies one cycle of inputs, advances the model on the edge, then samples 1 time unit later.
    task automatic drive(input logic v, input logic [7:0] d, input logic wr, input logic cl, input logic rs);
        char_valid = v; char_data = d; word_ready = wr; clear = cl; reset = rs;
        @(posedge clk);
        m_wr_en = 0;
        m_err = 0;
        if (rs) begin
            mq.delete(); m_full = 0; m_wr_addr = '0; m_wr_bit = 0;
        end else if (m_full) begin
            if (wr) begin mq.delete(); m_full = 0; end
        end else if (cl) begin
            mq.delete();
        end else if (v) begin
            if (d == "0" || d == "1") begin
                m_wr_en = 1; m_wr_addr = AW'(mq.size()); m_wr_bit = d[0];
                mq.push_back(d[0]);
                if (mq.size() == W) m_full = 1;
            end else if (d == 8'h08) begin
                if (mq.size() > 0) void'(mq.pop_back());
            end else begin
                m_err = 1;
            end
        end
        #1;
        char_valid = 0; word_ready = 0; clear = 0; reset = 0;
    endtask

    task automatic test_reset();
        drive(0, 8'h00, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 1);
        char_valid = 0;
        tests++; if (addr !== 0 || wr_addr !== 0) begin fails++; $display("FAIL reset_addr addr=%0d wr_addr=%0d required 0/0", addr, wr_addr); end
        tests++; if (wr_en !== 0 || err !== 0 || wr_bit !== 0) begin fails++; $display("FAIL reset_strobes wr_en=%b err=%b wr_bit=%b required 0", wr_en, err, wr_bit); end
        tests++; if (word_out !== 0 || word_rev !== 0 || word_valid !== 0) begin fails++; $display("FAIL reset_word out=%h rev=%h valid=%b required 0", word_out, word_rev, word_valid); end
        tests++; if (char_ready !== 1) begin fails++; $display("FAIL reset_ready char_ready=%b required 1", char_ready); end
    endtask

    task automatic test_gaps();
        logic [7:0] seq [8] = '{"0", "1", "0", "0", "1", "1", "1", "1"};
        int bad = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, seq[k], 0, 0, 0);
            if (wr_en !== 1 || wr_addr !== AW'(k) || wr_bit !== seq[k][0]) bad++;
            if (k < 7) for (int g = $urandom_range(0, 3); g > 0; g--) begin
                drive(0, 8'h31, 0, 0, 0);
                if (wr_en !== 0) bad++;
            end
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL gaps_strobes bad_cycles=%0d required 0", bad); end
        tests++; if (word_valid !== 1 || char_ready !== 0) begin fails++; $display("FAIL gaps_full valid=%b ready=%b required 1/0", word_valid, char_ready); end
        tests++; if (word_out !== 8'hF2 || word_rev !== 8'h4F) begin fails++; $display("FAIL gaps_word out=%h rev=%h required f2/4f", word_out, word_rev); end
        drive(0, 8'h00, 1, 0, 0);
        tests++; if (word_valid !== 0 || word_out !== 0 || char_ready !== 1) begin fails++; $display("FAIL gaps_release valid=%b out=%h ready=%b required 0/00/1", word_valid, word_out, char_ready); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, "1", 0, 0, 0);
            if (wr_en === 1 && wr_addr === AW'(k)) pulses++;
        end
        tests++; if (pulses != 8) begin fails++; $display("FAIL b2b_pulses got=%0d required 8", pulses); end
        tests++; if (word_out !== 8'hFF || addr !== 0 || word_valid !== 1) begin fails++; $display("FAIL b2b_word out=%h addr=%0d valid=%b required ff/0/1", word_out, addr, word_valid); end
        drive(0, 8'h00, 1, 0, 0);
    endtask

    task automatic test_err();
        drive(1, "1", 0, 0, 0);
        tests++; if (err !== 0) begin fails++; $display("FAIL err_before err=%b required 0", err); end
        drive(1, "A", 0, 0, 0);
        tests++; if (err !== 1 || wr_en !== 0) begin fails++; $display("FAIL err_pulse err=%b wr_en=%b required 1/0", err, wr_en); end
        drive(1, "0", 0, 0, 0);
        tests++; if (err !== 0 || wr_en !== 1) begin fails++; $display("FAIL err_after err=%b wr_en=%b required 0/1", err, wr_en); end
        tests++; if (addr !== 2 || word_out[1:0] !== 2'b01) begin fails++; $display("FAIL err_state addr=%0d word=%b required 2/01", addr, word_out[1:0]); end
        drive(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_full_hold();
        logic [7:0] w = 8'($urandom);
        int bad = 0;
        for (int k = 0; k < 8; k++) drive(1, w[k] ? "1" : "0", 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, "1", 0, 0, 0);
            if (word_valid !== 1 || char_ready !== 0 || wr_en !== 0 || word_out !== w || word_rev !== reverse(w)) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL hold_stable bad_cycles=%0d required 0 (word %h)", bad, w); end
        drive(1, "1", 1, 1, 0);
        tests++; if (word_valid !== 0 || word_out !== 0 || char_ready !== 1 || wr_en !== 0) begin fails++; $display("FAIL hold_release valid=%b out=%h ready=%b wr_en=%b required 0/00/1/0", word_valid, word_out, char_ready, wr_en); end
    endtask

    task automatic test_backspace();
        drive(1, "1", 0, 0, 0);
        drive(1, "1", 0, 0, 0);
        drive(1, 8'h08, 0, 0, 0);
        tests++; if (addr !== 1 || word_out !== 8'h01 || wr_en !== 0 || err !== 0) begin fails++; $display("FAIL bs_pop addr=%0d out=%h wr_en=%b err=%b required 1/01/0/0", addr, word_out, wr_en, err); end
        drive(1, 8'h08, 0, 0, 0);
        drive(1, 8'h08, 0, 0, 0);
        tests++; if (addr !== 0 || word_out !== 0 || err !== 0) begin fails++; $display("FAIL bs_empty addr=%0d out=%h err=%b required 0/00/0", addr, word_out, err); end
    endtask

    task automatic test_clear_reset();
        for (int k = 0; k < 5; k++) drive(1, "1", 0, 0, 0);
        drive(1, "1", 0, 1, 0);
        tests++; if (addr !== 0 || word_out !== 0 || wr_en !== 0 || err !== 0) begin fails++; $display("FAIL clear addr=%0d out=%h wr_en=%b err=%b required 0/00/0/0", addr, word_out, wr_en, err); end
        for (int k = 0; k < 3; k++) drive(1, "1", 0, 0, 0);
        drive(1, "0", 0, 0, 1);
        tests++; if (addr !== 0 || word_out !== 0 || wr_en !== 0 || char_ready !== 1) begin fails++; $display("FAIL midreset addr=%0d out=%h wr_en=%b ready=%b required 0/00/0/1", addr, word_out, wr_en, char_ready); end
        for (int k = 0; k < 8; k++) drive(1, "1", 0, 0, 0);
        drive(0, 8'h00, 0, 1, 0);
        tests++; if (word_valid !== 1 || word_out !== 8'hFF) begin fails++; $display("FAIL clear_full valid=%b out=%h required 1/ff", word_valid, word_out); end
        drive(0, 8'h00, 0, 0, 1);
        tests++; if (word_valid !== 0 || word_out !== 0 || char_ready !== 1) begin fails++; $display("FAIL full_reset valid=%b out=%h ready=%b required 0/00/1", word_valid, word_out, char_ready); end
    endtask

    task automatic test_random();
        logic [7:0] codes [4] = '{"0", "1", 8'h08, 8'h41};
        logic [7:0] d;
        logic [W*2+2*AW+6:0] got, exp;
        for (int n = 0; n < 600; n++) begin
            d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : codes[$urandom_range(0, 2)];
            if ($urandom_range(0, 15) == 0) d = codes[3];
            drive(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 90) == 0));
            got = {addr, wr_addr, wr_en, wr_bit, err, word_out, word_rev, word_valid, char_ready, 1'b0};
            exp = {m_addr(), m_wr_addr, m_wr_en, m_wr_bit, m_err, m_word(), reverse(m_word()), m_full, !m_full, 1'b0};
            tests++; if (got !== exp) begin fails++; $display("FAIL random cycle %0d got=%h required=%h", n, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_gaps();
        test_back_to_back();
        test_err();
        test_full_hold();
        test_backspace();
        test_clear_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
